// File: rtl/bldc_commutator.sv
// Six-step BLDC commutator: hall-driven gate patterns with PWM high side, dead-time and fault latch.
// Optional hall debounce filter enabled by defining HALL_FILTER_EN.
module bldc_commutator #(
  parameter int unsigned PWM_W      = 8,
  parameter int unsigned DEADTIME   = 4,
  parameter int unsigned PERIOD_W   = 16,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                dir,
  input  logic [PWM_W-1:0]    duty,
  input  logic [2:0]          hall,
  output logic [1:0]          pha,
  output logic [1:0]          phb,
  output logic [1:0]          phc,
  output logic                fault,
  output logic [PERIOD_W-1:0] hall_period,
  output logic                period_valid
);

  localparam int unsigned DT_W = 8;
  localparam logic [1:0] PH_A = 2'd0, PH_B = 2'd1, PH_C = 2'd2, PH_NONE = 2'd3;

  if (DEADTIME < 1 || DEADTIME > 255 || FILTER_LEN < 1) begin : g_bad_param
    $error("bldc_commutator: DEADTIME must be 1..255 and FILTER_LEN >= 1");
  end

  // Table position of a hall code; 7 marks the illegal codes 000/111
  function automatic logic [2:0] hall_idx(input logic [2:0] h);
    case (h)
      3'b001:  return 3'd0;
      3'b011:  return 3'd1;
      3'b010:  return 3'd2;
      3'b110:  return 3'd3;
      3'b100:  return 3'd4;
      3'b101:  return 3'd5;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [2:0] idx_next(input logic [2:0] i);
    return (i == 3'd5) ? 3'd0 : i + 3'd1;
  endfunction

  // Returns {high_phase, low_phase}; reverse swaps the roles
  function automatic logic [3:0] pattern(input logic [2:0] i, input logic rev);
    logic [1:0] hi, lo;
    case (i)
      3'd0:    begin hi = PH_A; lo = PH_B; end
      3'd1:    begin hi = PH_A; lo = PH_C; end
      3'd2:    begin hi = PH_B; lo = PH_C; end
      3'd3:    begin hi = PH_B; lo = PH_A; end
      3'd4:    begin hi = PH_C; lo = PH_A; end
      3'd5:    begin hi = PH_C; lo = PH_B; end
      default: begin hi = PH_NONE; lo = PH_NONE; end
    endcase
    return rev ? {lo, hi} : {hi, lo};
  endfunction

  function automatic logic [1:0] gate(input logic [1:0] ph, input logic [1:0] hi,
                                      input logic [1:0] lo, input logic on);
    if (ph == hi)      return {on, 1'b0};
    else if (ph == lo) return 2'b01;
    else               return 2'b00;
  endfunction

  logic [2:0]          sync1_q, sync2_q, hall_acc_c;
  logic [2:0]          hall_last_q, hall_last_d;
  logic                en_q, en_d, dir_q, dir_d, first_q, first_d;
  logic                fault_q, fault_d, pv_q, pv_d;
  logic [DT_W-1:0]     dt_q, dt_d;
  logic [PWM_W-1:0]    pwm_cnt_q, pwm_cnt_d, duty_q, duty_d;
  logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d, hall_period_q, hall_period_d;
  logic [1:0]          pha_q, pha_d, phb_q, phb_d, phc_q, phc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= hall;
      sync2_q <= sync1_q;
    end
  end

`ifdef HALL_FILTER_EN
  localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
  logic [2:0]       flt_val_q;
  logic [FLT_W-1:0] flt_cnt_q;

  // A value is released only once it has been seen FILTER_LEN cycles in a row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flt_val_q <= '0;
      flt_cnt_q <= '0;
    end else if (sync2_q != flt_val_q) begin
      flt_val_q <= sync2_q;
      flt_cnt_q <= FLT_W'(1);
    end else if (flt_cnt_q != FLT_W'(FILTER_LEN)) begin
      flt_cnt_q <= flt_cnt_q + FLT_W'(1);
    end
  end

  assign hall_acc_c = (flt_cnt_q == FLT_W'(FILTER_LEN)) ? flt_val_q : hall_last_q;
`else
  assign hall_acc_c = sync2_q;
`endif

  logic       rise_c, chg_c, new_ok_c, last_ok_c, adj_c, bad_c, acc_c, pwm_on_c;
  logic [2:0] new_idx_c, last_idx_c;
  logic [3:0] pat_c;

  always_comb begin
    hall_last_d   = hall_acc_c;
    en_d          = en;
    dir_d         = dir;
    first_d       = first_q;
    fault_d       = 1'b0;
    pv_d          = 1'b0;
    dt_d          = '0;
    pwm_cnt_d     = pwm_cnt_q + PWM_W'(1);
    duty_d        = (pwm_cnt_q == '1) ? duty : duty_q;
    per_cnt_d     = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + PERIOD_W'(1);
    hall_period_d = hall_period_q;
    pha_d         = 2'b00;
    phb_d         = 2'b00;
    phc_d         = 2'b00;

    rise_c     = en & ~en_q;
    new_idx_c  = hall_idx(hall_acc_c);
    last_idx_c = hall_idx(hall_last_q);
    new_ok_c   = (new_idx_c != 3'd7);
    last_ok_c  = (last_idx_c != 3'd7);
    adj_c      = (idx_next(new_idx_c) == last_idx_c) || (idx_next(last_idx_c) == new_idx_c);
    chg_c      = (hall_acc_c != hall_last_q);
    bad_c      = chg_c && (!new_ok_c || (last_ok_c && !adj_c));
    acc_c      = chg_c && !bad_c;
    pwm_on_c   = (pwm_cnt_q < duty_q);

    if (en) begin
      fault_d = fault_q | bad_c;
      if (acc_c || rise_c || (dir != dir_q)) dt_d = DT_W'(DEADTIME);
      else if (dt_q != '0)                   dt_d = dt_q - DT_W'(1);
    end

    // Period is only meaningful between two legal, adjacent positions
    if (acc_c) begin
      per_cnt_d     = PERIOD_W'(1);
      hall_period_d = per_cnt_q;
      pv_d          = en && !first_q && !rise_c && !fault_q && last_ok_c;
      first_d       = 1'b0;
    end
    if (rise_c) first_d = 1'b1;

    pat_c = pattern(hall_idx(hall_last_d), dir);
    if (en && !fault_d && (dt_d == '0)) begin
      pha_d = gate(PH_A, pat_c[3:2], pat_c[1:0], pwm_on_c);
      phb_d = gate(PH_B, pat_c[3:2], pat_c[1:0], pwm_on_c);
      phc_d = gate(PH_C, pat_c[3:2], pat_c[1:0], pwm_on_c);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hall_last_q   <= '0;
      en_q          <= 1'b0;
      dir_q         <= 1'b0;
      first_q       <= 1'b1;
      fault_q       <= 1'b0;
      pv_q          <= 1'b0;
      dt_q          <= '0;
      pwm_cnt_q     <= '0;
      duty_q        <= '0;
      per_cnt_q     <= '0;
      hall_period_q <= '0;
      pha_q         <= 2'b00;
      phb_q         <= 2'b00;
      phc_q         <= 2'b00;
    end else begin
      hall_last_q   <= hall_last_d;
      en_q          <= en_d;
      dir_q         <= dir_d;
      first_q       <= first_d;
      fault_q       <= fault_d;
      pv_q          <= pv_d;
      dt_q          <= dt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      duty_q        <= duty_d;
      per_cnt_q     <= per_cnt_d;
      hall_period_q <= hall_period_d;
      pha_q         <= pha_d;
      phb_q         <= phb_d;
      phc_q         <= phc_d;
    end
  end

  assign pha          = pha_q;
  assign phb          = phb_q;
  assign phc          = phc_q;
  assign fault        = fault_q;
  assign hall_period  = hall_period_q;
  assign period_valid = pv_q;

endmodule

// File: doc/bldc_commutator.md
BLDC_COMMUTATOR -- requirements
Module: bldc_commutator

Interface
REQ-001 Parameter PWM_W, default 8, SHALL set the duty and PWM counter width.
REQ-002 Parameter DEADTIME, default 4, SHALL set the number of all-off clock cycles inserted on every pattern change (range 1..255).
REQ-003 Parameter PERIOD_W, default 16, SHALL set the hall period counter width.
REQ-004 Parameter FILTER_LEN, default 3, SHALL set the hall stability count, used only with HALL_FILTER_EN.
REQ-005 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-006 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-007 en  input  1  SHALL be the drive enable.
REQ-008 dir  input  1  SHALL select rotation: 0 forward, 1 reverse.
REQ-009 duty  input  PWM_W  SHALL be the high-side duty command.
REQ-010 hall  input  3  SHALL be the asynchronous hall sensor inputs {C,B,A}.
REQ-011 pha, phb, phc  output  2 each  SHALL be the gate drives: bit1 is the high-side gate, bit0 is the low-side gate.
REQ-012 fault  output  1  SHALL be the sticky hall fault flag.
REQ-013 hall_period  output  PERIOD_W  SHALL hold the clock count between the last two accepted hall changes.
REQ-014 period_valid  output  1  SHALL pulse for one cycle when hall_period updates.

Function
REQ-015 The hall input SHALL pass through a 2-flop synchronizer before any use.
REQ-016 The forward table SHALL be (hall: high/low phase): 001 A/B, 011 A/C, 010 B/C, 110 B/A, 100 C/A, 101 C/B.
- Undriven phase = 00.
- Driven low phase = 01.
- Driven high phase = {pwm_on, 0}.
REQ-017 dir=1 SHALL swap the high and low phase of each table entry.
REQ-018 A free-running PWM_W-bit counter SHALL wrap from all-ones to 0.
- pwm_on = (cnt < duty_q).
- duty_q loads duty when cnt is all-ones.
- duty=0 gives never on; duty=2^PWM_W-1 gives off for 1 cycle per period.
REQ-019 Any change of the table pattern SHALL force all six gates to 0 for exactly DEADTIME cycles before the new pattern is applied. Pattern changes are caused by an accepted hall change, a dir change, or en rising.
REQ-020 With HALL_FILTER_EN undefined, timing SHALL be as follows, with cycles counted as rising edges after the hall input changes:
- Outputs go to 00 at cycle 3.
- The new pattern appears at cycle 3+DEADTIME.
REQ-021 A new pattern change during dead-time SHALL restart the DEADTIME count, and the latest pattern SHALL be applied when the count completes.
REQ-022 Hall 000 or 111, or an accepted change to a non-adjacent table entry, SHALL set fault.
- All gates go to 00 on the next cycle.
- Outputs stay 00 until en is low for at least one cycle.
REQ-023 en=0 SHALL drive all gates to 00 on the next cycle, clear fault, and clear the dead-time counter.
REQ-024 The period counter SHALL increment every cycle and saturate at all-ones. On each accepted valid hall change:
- hall_period loads the count.
- The counter restarts at 1.
- period_valid pulses.
REQ-025 The first accepted change after reset or after en rising SHALL NOT assert period_valid.
REQ-026 Outputs SHALL never drive 11 on any phase, in any cycle.

Reset
REQ-027 While rst=1, the following SHALL hold and SHALL be taken asynchronously:
- pha, phb, phc = 00.
- fault = 0.
- hall_period = 0.
- period_valid = 0.
- PWM counter = 0, duty_q = 0.
- Synchronizer and filter state = 0.
REQ-028 After rst falls with en=1, the first pattern SHALL appear only after a full DEADTIME all-off interval.

Configuration
REQ-029 With macro HALL_FILTER_EN defined, a synchronized hall value SHALL be accepted only after it has been stable for FILTER_LEN consecutive cycles, adding FILTER_LEN cycles to REQ-020 latency.
REQ-030 With HALL_FILTER_EN undefined, the synchronized hall value SHALL be accepted directly, and no filter logic shall be present.

Verification (PWM_W=8, DEADTIME=4, FILTER_LEN=3)
REQ-031 Reset: assert rst mid-PWM with en=1 -> outputs 00, fault 0, period_valid 0 on the same edge with no clock required.
REQ-032 Drive: en=1, dir=0, duty=128, hall=001 stable -> pha high-side on for 128 of every 256 cycles, phb=01, phc=00.
REQ-033 Commutate: hall 001->011 after 1000 cycles -> all 00 for 4 cycles, then pha PWM, phc=01; period_valid pulses with hall_period=1000.
REQ-034 Fault: hall=111 for 5 cycles, then 001 -> fault=1 and outputs 00, held until en=0 for one cycle, then normal after 4 off cycles.
REQ-035 Reverse: dir 0->1 at hall=001 -> 00 for 4 cycles, then phb PWM, pha=01; no 11 on any phase throughout.
REQ-036 Filter: 1-cycle hall glitch 001->000->001 -> with HALL_FILTER_EN, no output change and fault=0; without it, fault=1.
